multiseg_scan_ctrl: RTL and testbench

MULTISEG_SCAN_CTRL -- requirements
Module: multiseg_scan_ctrl

---
 rtl/multiseg_scan_ctrl_if.sv | 25 ++
 rtl/multiseg_scan_ctrl.sv | 90 +++++++++
 tb/tb_multiseg_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/multiseg_scan_ctrl_if.sv
// multiseg_scan_ctrl_if: digit load/brightness inputs and display drive outputs of the scan controller
interface multiseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic                  load;
    logic [IW-1:0]         load_digit;
    logic [3:0]            load_value;
    logic [2:0]            brightness;
    logic [3:0]            digit_value;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_tick;
    logic                  load_err;

    modport master (
        output load, load_digit, load_value, brightness,
        input  digit_value, digit_en, frame_tick, load_err
    );

    modport slave (
        input  load, load_digit, load_value, brightness,
        output digit_value, digit_en, frame_tick, load_err
    );
endinterface

// File: rtl/multiseg_scan_ctrl.sv
// multiseg_scan_ctrl: multiplexed BCD digit scanner with blanking, PWM dimming and double-buffered values
module multiseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input logic                 clk,
    input logic                 reset,
    multiseg_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, ON} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_slot_cnt;
    logic [IW-1:0]         r_digit_idx;
    logic [3:0]            r_shadow [NUM_DIGITS];
    logic [3:0]            r_active [NUM_DIGITS];
    logic                  r_dirty;
    logic [NUM_DIGITS-1:0] r_digit_en;
    logic [3:0]            r_digit_value;
    logic                  r_frame_tick;
    logic                  r_load_err;

    logic [2**IW-1:0]      w_digit_ok;
    logic                  w_wrap;
    logic                  w_frame_end;
    logic                  w_commit;
    logic                  w_load_ok;
    logic                  w_on_n;
    logic [CW-1:0]         w_cnt_n;
    logic [IW-1:0]         w_idx_n;

    // Index codes beyond NUM_DIGITS (only possible when it is not a power of two) are rejected
    for (genvar g = 0; g < 2**IW; g++) begin : g_digit_ok
        assign w_digit_ok[g] = g < NUM_DIGITS;
    end

    assign w_wrap      = r_slot_cnt == LAST_CNT;
    assign w_frame_end = w_wrap && r_digit_idx == LAST_IDX;
    assign w_commit    = w_frame_end && r_dirty;
    assign w_cnt_n     = w_wrap ? '0 : r_slot_cnt + 1'b1;
    assign w_idx_n     = !w_wrap ? r_digit_idx : (r_digit_idx == LAST_IDX ? '0 : r_digit_idx + 1'b1);
    assign w_on_n      = r_state == ON ? !w_wrap : w_cnt_n == BLANK_END;
    assign w_load_ok   = bus.load && bus.load_value <= 4'd9 && w_digit_ok[bus.load_digit];

    assign bus.digit_en    = r_digit_en;
    assign bus.digit_value = r_digit_value;
    assign bus.frame_tick  = r_frame_tick;
    assign bus.load_err    = r_load_err;

    // Slot/digit counters and blank/on FSM; outputs are computed from next-state so they align with the counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt    <= '0;
            r_digit_idx   <= '0;
            r_state       <= BLANK;
            r_digit_en    <= '0;
            r_digit_value <= '0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_slot_cnt   <= w_cnt_n;
            r_digit_idx  <= w_idx_n;
            r_state      <= w_on_n ? ON : BLANK;
            r_digit_en   <= (w_on_n && w_cnt_n[2:0] <= bus.brightness) ? NUM_DIGITS'(1) << w_idx_n : '0;
            r_frame_tick <= w_frame_end;
            if (w_wrap) r_digit_value <= w_commit ? r_shadow[w_idx_n] : r_active[w_idx_n];
        end
    end

    // Shadow bank takes accepted loads; active bank picks up the pre-write shadow at a dirty frame end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow   <= '{default: '0};
            r_active   <= '{default: '0};
            r_dirty    <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            if (w_commit) r_active <= r_shadow;
            if (w_load_ok) r_shadow[bus.load_digit] <= bus.load_value;
            r_dirty    <= w_load_ok || (r_dirty && !w_frame_end);
            r_load_err <= bus.load && !w_load_ok;
        end
    end
endmodule

// File: tb/tb_multiseg_scan_ctrl.sv
// tb_multiseg_scan_ctrl: model-checked bench for the multiplexed digit scanner
module tb_multiseg_scan_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    int   m_k    = 0;
    int   ticks  = 0;
    logic [3:0] sh [4];
    logic [3:0] ac [4];
    bit         dirty;
    logic [3:0] e_en, e_val;
    logic       e_tick, e_err;
    int         cnt;

    multiseg_scan_ctrl_if #(.NUM_DIGITS(4)) b ();
    multiseg_scan_ctrl_if #(.NUM_DIGITS(5)) b5 ();

    multiseg_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV(64), .BLANK_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .bus(b.slave)
    );
    multiseg_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(64), .BLANK_CYCLES(8)) u5 (
        .clk(clk), .reset(reset), .bus(b5.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_k);
        end
    endtask

    // Model: cycle k after reset release is slot k/64, digit (k/64)%4, position k%64; a frame is 256 cycles
    always @(negedge clk) begin
        chk("onehot_main", 32'($onehot0(b.digit_en)), 1);
        chk("onehot_u5", 32'($onehot0(b5.digit_en)), 1);
        if (reset) begin
            chk("rst_en", b.digit_en, 0);
            chk("rst_val", b.digit_value, 0);
            chk("rst_tick", b.frame_tick, 0);
            chk("rst_err", b.load_err, 0);
            m_k = 0; ticks = 0; dirty = 0;
            sh = '{default: 4'd0};
            ac = '{default: 4'd0};
            e_en = 0; e_val = 0; e_tick = 0; e_err = 0;
        end else begin
            chk("digit_en", b.digit_en, e_en);
            chk("digit_value", b.digit_value, e_val);
            chk("frame_tick", b.frame_tick, e_tick);
            chk("load_err", b.load_err, e_err);
            if (b.frame_tick) ticks++;
            begin
                bit fe, ok;
                int idx, pos;
                fe = (m_k % 256) == 255;
                ok = b.load && b.load_value <= 9;
                if (fe && dirty) ac = sh;
                if (ok) sh[b.load_digit] = b.load_value;
                dirty  = ok || (dirty && !fe);
                e_err  = b.load && !ok;
                e_tick = fe;
                m_k++;
                idx = (m_k / 64) % 4;
                pos = m_k % 64;
                e_en  = (pos >= 8 && (pos % 8) <= int'(b.brightness)) ? 4'(1 << idx) : 4'd0;
                e_val = ac[idx];
            end
        end
    end

    task automatic go(input int t);
        int n = 0;
        while (m_k != t && n < 4000) begin
            @(posedge clk); #2;
            n++;
        end
        chk("reach_cycle", m_k, t);
    endtask

    task automatic ld(input logic [1:0] d, input logic [3:0] v);
        b.load = 1'b1; b.load_digit = d; b.load_value = v;
        @(posedge clk); #2;
        b.load = 1'b0;
    endtask

    task automatic ld5(input logic [2:0] d, input logic [3:0] v);
        b5.load = 1'b1; b5.load_digit = d; b5.load_value = v;
        @(posedge clk); #2;
        b5.load = 1'b0;
    endtask

    task automatic count_on(output int c);
        c = 0;
        for (int i = 0; i < 56; i++) begin
            if (b.digit_en != 0) c++;
            @(posedge clk); #2;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b.load = 0; b.load_digit = 0; b.load_value = 0; b.brightness = 3'd7;
        b5.load = 0; b5.load_digit = 0; b5.load_value = 0; b5.brightness = 3'd7;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        ld5(3'd5, 4'd3);  chk("u5_err_digit5", b5.load_err, 1);
        ld5(3'd7, 4'd3);  chk("u5_err_digit7", b5.load_err, 1);
        ld5(3'd4, 4'd12); chk("u5_err_value12", b5.load_err, 1);
        ld5(3'd4, 4'd3);  chk("u5_ok_load", b5.load_err, 0);
        go(7);   chk("blank_pos7", b.digit_en, 4'b0000);
        go(8);   chk("slot0_on", b.digit_en, 4'b0001);
        go(72);  chk("slot1_on", b.digit_en, 4'b0010);
        go(136); chk("slot2_on", b.digit_en, 4'b0100);
        go(200); chk("slot3_on", b.digit_en, 4'b1000);
        go(256); chk("tick_frame1", b.frame_tick, 1);
        go(266); chk("u5_slot4_old", b5.digit_value, 0);
        go(320); chk("u5_tick", b5.frame_tick, 1);
        go(513); chk("tick_count", ticks, 2);
        go(582); ld(2'd2, 4'd7);
        go(586); chk("u5_slot4_new", b5.digit_value, 3);
        go(650); chk("slot2_before_commit", b.digit_value, 0);
        go(842); chk("slot1_after_commit", b.digit_value, 0);
        go(906); chk("slot2_after_commit", b.digit_value, 7);
        go(920); ld(2'd1, 4'd12);
        chk("err_value12", b.load_err, 1);
        @(posedge clk); #2;
        chk("err_one_cycle", b.load_err, 0);
        go(1024); b.brightness = 3'd0;
        go(1032); count_on(cnt); chk("bright0_on_count", cnt, 7);
        b.brightness = 3'd3;
        go(1096); count_on(cnt); chk("bright3_on_count", cnt, 28);
        b.brightness = 3'd7;
        go(1160); ld(2'd0, 4'd5);
        go(1279); ld(2'd0, 4'd9);
        go(1290); chk("frame_end_old_commit", b.digit_value, 5);
        go(1546); chk("frame_end_new_later", b.digit_value, 9);
        go(1748); chk("digit3_on_pre_reset", b.digit_en, 4'b1000);
        reset = 1'b1;
        #1 chk("async_reset_en", b.digit_en, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        go(8);   chk("restart_digit0", b.digit_en, 4'b0001);
        chk("restart_value0", b.digit_value, 0);
        go(906); chk("restart_slot2_cleared", b.digit_value, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
